// File: rtl/deadlock_idx0_monitor_pkg.sv
// Shared defaults and index helpers for the dataflow-region deadlock monitor.
// Imported by the interface, the per-process decoder and the top.
package deadlock_mon_pkg;
    localparam int N_PROC_DEF          = 2;
    localparam int N_IDLE_DEF          = 2 * N_PROC_DEF + 1;
    localparam int STALL_THRESHOLD_DEF = 16;
    localparam int CNT_W_DEF           = 5;

    function automatic int idx_secondary_idle(input int i, input int n_proc);
        return n_proc + 1 + i;
    endfunction
endpackage

// File: rtl/deadlock_idx0_monitor_if.sv
// Probe bundle: per-process stall/idle flags in, deadlock indication out.
// The master side is the probed region, the slave side is the monitor.
interface deadlock_idx0_monitor_if
    import deadlock_mon_pkg::*;
#(
    parameter int N_PROC = N_PROC_DEF,
    parameter int N_IDLE = N_IDLE_DEF
) ();
    logic [N_PROC-1:0] axis_block_sigs;
    logic [N_IDLE-1:0] inst_idle_sigs;
    logic [N_PROC-1:0] inst_block_sigs;
    logic              block;

    modport master (
        output axis_block_sigs,
        output inst_idle_sigs,
        output inst_block_sigs,
        input  block
    );

    modport slave (
        input  axis_block_sigs,
        input  inst_idle_sigs,
        input  inst_block_sigs,
        output block
    );
endinterface

// File: rtl/deadlock_idx0_monitor_proc_status.sv
// Per-process decode: stalled, and quiet (stalled or idle in both views).
// Idle only counts when the primary and secondary idle views agree.
module deadlock_proc_status (
    input  logic axis_block,
    input  logic inst_block,
    input  logic idle_primary,
    input  logic idle_secondary,
    output logic stalled,
    output logic quiet
);
    logic idle;

    assign stalled = axis_block | inst_block;
    assign idle    = idle_primary & idle_secondary;
    assign quiet   = stalled | idle;
endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for a two-process dataflow region: block asserts after
// STALL_THRESHOLD consecutive cycles of all-quiet with at least one stall.
module deadlock_idx0_monitor
    import deadlock_mon_pkg::*;
#(
    parameter int N_PROC          = N_PROC_DEF,
    parameter int N_IDLE          = N_IDLE_DEF,
    parameter int STALL_THRESHOLD = STALL_THRESHOLD_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    deadlock_idx0_monitor_if.slave  bus
);
    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(STALL_THRESHOLD - 1);

    logic [N_PROC-1:0] stalled;
    logic [N_PROC-1:0] quiet;
    logic              region_idle;
    logic              dl_cond;
    logic [CNT_W-1:0]  cnt;
    logic              block_q;

    for (genvar i = 0; i < N_PROC; i++) begin : g_proc
        deadlock_proc_status u_status (
            .axis_block     (bus.axis_block_sigs[i]),
            .inst_block     (bus.inst_block_sigs[i]),
            .idle_primary   (bus.inst_idle_sigs[i]),
            .idle_secondary (bus.inst_idle_sigs[idx_secondary_idle(i, N_PROC)]),
            .stalled        (stalled[i]),
            .quiet          (quiet[i])
        );
    end

    // A finished region is never a deadlock, whatever the stall flags say.
    assign region_idle = bus.inst_idle_sigs[N_PROC];
    assign dl_cond     = (&quiet) & (|stalled) & ~region_idle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            block_q <= 1'b0;
        end else if (!dl_cond) begin
            cnt     <= '0;
            block_q <= 1'b0;
        end else if (cnt < THR_M1) begin
            cnt     <= cnt + 1'b1;
        end else begin
            block_q <= 1'b1;
        end
    end

    assign bus.block = block_q;
endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Scoreboard bench: driver pushes expected block per edge from a run-length
// model; a monitor pops and compares after every rising edge.
module tb_deadlock_idx0_monitor;
    localparam int THR = 16;

    logic clk;
    logic rst_n;

    deadlock_idx0_monitor_if #(.N_PROC(2), .N_IDLE(5)) mon_if ();

    deadlock_idx0_monitor #(
        .N_PROC(2), .N_IDLE(5), .STALL_THRESHOLD(THR), .CNT_W(5)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit exp_q[$];
    int checks = 0;
    int errors = 0;
    int run    = 0;
    int cyc    = 0;

    function automatic bit deadlocked(logic [1:0] a, logic [4:0] id, logic [1:0] ib);
        bit all_quiet = 1'b1;
        bit any_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit s  = a[i] | ib[i];
            bit dn = id[i] & id[3+i];
            if (!(s || dn)) all_quiet = 1'b0;
            if (s) any_stall = 1'b1;
        end
        return all_quiet && any_stall && !id[2];
    endfunction

    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            bit e;
            e = exp_q.pop_front();
            checks++;
            if (mon_if.block !== e) begin
                errors++;
                $display("FAIL block cyc=%0d got %b exp %b", cyc, mon_if.block, e);
            end
        end
    end

    task automatic step(input logic [1:0] a, input logic [4:0] id,
                        input logic [1:0] ib, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mon_if.axis_block_sigs = a;
            mon_if.inst_idle_sigs  = id;
            mon_if.inst_block_sigs = ib;
            if (!rst_n) run = 0;
            else if (deadlocked(a, id, ib)) run++;
            else run = 0;
            exp_q.push_back(run >= THR);
            @(posedge clk);
        end
    endtask

    // Called right after a rising edge; reset pulse sits entirely between edges.
    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mon_if.block !== 1'b0) begin
            errors++;
            $display("FAIL %s got %b exp 0", tag, mon_if.block);
        end
        #1 rst_n = 1'b1;
        run = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        mon_if.axis_block_sigs = 2'b11;
        mon_if.inst_idle_sigs  = 5'b00000;
        mon_if.inst_block_sigs = 2'b11;
        #1;
        checks++;
        if (mon_if.block !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got %b exp 0", mon_if.block);
        end
        step(2'b11, 5'b00000, 2'b11, 20);
        #2 rst_n = 1'b1;

        // true deadlock, break, reapply, saturate
        step(2'b01, 5'b10010, 2'b00, 20);
        step(2'b00, 5'b10010, 2'b00, 1);
        step(2'b01, 5'b10010, 2'b00, 40);
        // done-without-continue stall path
        step(2'b00, 5'b10010, 2'b00, 3);
        step(2'b00, 5'b10010, 2'b01, 20);
        // normal finish and region-idle override
        step(2'b00, 5'b11011, 2'b00, 100);
        step(2'b11, 5'b00100, 2'b00, 20);
        // active process, and a single idle view only
        step(2'b01, 5'b00000, 2'b00, 30);
        step(2'b01, 5'b00010, 2'b00, 20);
        // async reset mid-count, then while block is high
        step(2'b01, 5'b10010, 2'b00, 10);
        pulse_reset("reset_midcount");
        step(2'b01, 5'b10010, 2'b00, 20);
        pulse_reset("reset_blocked");
        step(2'b01, 5'b10010, 2'b00, 18);

        for (int s = 0; s < 60; s++) begin
            logic [1:0] a, ib;
            logic [4:0] id;
            int len;
            a   = 2'($urandom);
            ib  = 2'($urandom);
            id  = 5'($urandom);
            if ($urandom_range(0, 1) == 1) id[2] = 1'b0;
            len = $urandom_range(1, 25);
            step(a, id, ib, len);
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
